// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared types and hazard helpers for the dual-issue stall/split scoreboard.
package dual_issue_pkg;

  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef enum logic {
    PAIR   = 1'b0,
    SECOND = 1'b1
  } sb_state_t;

  // One in-flight destination: valid, register index, writes RF, is a load.
  typedef struct packed {
    logic          v;
    logic [RW-1:0] regnum;
    logic          rw;
    logic          ld;
  } sb_entry_t;

  // Register 0 is hardwired, so it never creates a dependence.
  function automatic logic src_hits(input logic [RW-1:0] src, input sb_entry_t e);
    return (src != '0) && e.v && e.rw && (e.regnum == src);
  endfunction

  // Hazards of one decode slot against the shadow Execute/Memory entries
  // that forwarding cannot cover.
  function automatic logic ext_hazard(
    input logic [RW-1:0] rs,
    input logic [RW-1:0] rt,
    input logic          br,
    input sb_entry_t     e1,
    input sb_entry_t     e2,
    input sb_entry_t     m1,
    input sb_entry_t     m2
  );
    logic hit_e1, hit_e2, hit_m1, hit_m2;
    logic load_use, branch_alu, branch_load;
    hit_e1      = src_hits(rs, e1) || src_hits(rt, e1);
    hit_e2      = src_hits(rs, e2) || src_hits(rt, e2);
    hit_m1      = src_hits(rs, m1) || src_hits(rt, m1);
    hit_m2      = src_hits(rs, m2) || src_hits(rt, m2);
    load_use    = (hit_e1 && e1.ld) || (hit_e2 && e2.ld);
    branch_alu  = br && (hit_e1 || hit_e2);
    branch_load = br && ((hit_m1 && m1.ld) || (hit_m2 && m2.ld));
    return load_use || branch_alu || branch_load;
  endfunction

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decode-slot inputs and stall/bubble outputs of the scoreboard.
// Handshake: no valid/ready pair here; validD1/validD2 qualify each slot and
// the outputs are a same-cycle combinational verdict on the presented bundle.
interface dual_issue_scoreboard_if;
  import dual_issue_pkg::*;

  logic          validD1, validD2;
  logic [RW-1:0] rsD1, rtD1, rsD2, rtD2;
  logic [RW-1:0] writeregD1, writeregD2;
  logic          regwriteD1, regwriteD2;
  logic          memtoregD1, memtoregD2;
  logic          branchD1, branchD2;
  logic          flushD;
  logic          stallF, stallD;
  logic          bubbleE1, bubbleE2;
  logic          splitD;
  sb_state_t     state_dbg;

  modport master (
    output validD1, validD2, rsD1, rtD1, rsD2, rtD2, writeregD1, writeregD2,
           regwriteD1, regwriteD2, memtoregD1, memtoregD2, branchD1, branchD2,
           flushD,
    input  stallF, stallD, bubbleE1, bubbleE2, splitD, state_dbg
  );

  modport slave (
    input  validD1, validD2, rsD1, rtD1, rsD2, rtD2, writeregD1, writeregD2,
           regwriteD1, regwriteD2, memtoregD1, memtoregD2, branchD1, branchD2,
           flushD,
    output stallF, stallD, bubbleE1, bubbleE2, splitD, state_dbg
  );

endinterface

// File: rtl/dual_issue_scoreboard_lane.sv
// Per-lane shadow of the destination in flight in Execute and Memory.
module sb_lane
  import dual_issue_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  sb_entry_t d_i,
  output sb_entry_t e_o,
  output sb_entry_t m_o
);

  sb_entry_t e_q, m_q;

  // E/M never stall: every cycle M takes E and E takes the issued slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      m_q <= e_q;
      e_q <= d_i;
    end
  end

  assign e_o = e_q;
  assign m_o = m_q;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Pair/split/stall decision for the dual-issue decode bundle.
module dual_issue_scoreboard
  import dual_issue_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  dual_issue_scoreboard_if.slave  sb
);

  sb_state_t state_q, state_d;
  sb_entry_t e1, m1, e2, m2;
  sb_entry_t d1, d2;
  logic      haz1, haz2_ext, haz2_intra;
  logic      stall_w, bubble1_w, bubble2_w;

  // A slot enters the shadow only when it really moves into Execute.
  always_comb begin
    d1        = '0;
    d2        = '0;
    d1.v      = sb.validD1 && !bubble1_w && !sb.flushD;
    d1.regnum = sb.writeregD1;
    d1.rw     = sb.regwriteD1;
    d1.ld     = sb.memtoregD1;
    d2.v      = sb.validD2 && !bubble2_w && !sb.flushD;
    d2.regnum = sb.writeregD2;
    d2.rw     = sb.regwriteD2;
    d2.ld     = sb.memtoregD2;
  end

  sb_lane u_lane1 (.clk(clk), .reset(reset), .d_i(d1), .e_o(e1), .m_o(m1));
  sb_lane u_lane2 (.clk(clk), .reset(reset), .d_i(d2), .e_o(e2), .m_o(m2));

  // Hazard terms; an invalid slot never has a hazard.
  always_comb begin
    haz1 = sb.validD1 &&
           ext_hazard(sb.rsD1, sb.rtD1, sb.branchD1, e1, e2, m1, m2);
    haz2_ext = sb.validD2 &&
               ext_hazard(sb.rsD2, sb.rtD2, sb.branchD2, e1, e2, m1, m2);
    haz2_intra = 1'b0;
    if (sb.validD1 && sb.validD2 && sb.regwriteD1 && (sb.writeregD1 != '0)) begin
      haz2_intra = (sb.rsD2 == sb.writeregD1) || (sb.rtD2 == sb.writeregD1) ||
                   (sb.regwriteD2 && (sb.writeregD2 == sb.writeregD1));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= PAIR;
    else       state_q <= state_d;
  end

  // Next state and stall/bubble outputs; a flush overrides everything.
  always_comb begin
    state_d   = state_q;
    stall_w   = 1'b0;
    bubble1_w = 1'b0;
    bubble2_w = 1'b0;
    if (sb.flushD) begin
      state_d   = PAIR;
      bubble1_w = 1'b1;
      bubble2_w = 1'b1;
    end else if (state_q == PAIR) begin
      if (haz1) begin
        stall_w   = 1'b1;
        bubble1_w = 1'b1;
        bubble2_w = 1'b1;
      end else if (haz2_ext || haz2_intra) begin
        stall_w   = 1'b1;
        bubble2_w = 1'b1;
        state_d   = SECOND;
      end
    end else begin
      // Slot 1 already left; its destination now sits in shadow E lane 1.
      bubble1_w = 1'b1;
      if (haz2_ext) begin
        stall_w   = 1'b1;
        bubble2_w = 1'b1;
      end else begin
        state_d = PAIR;
      end
    end
  end

  assign sb.stallF    = stall_w;
  assign sb.stallD    = stall_w;
  assign sb.bubbleE1  = bubble1_w;
  assign sb.bubbleE2  = bubble2_w;
  assign sb.splitD    = (state_q == SECOND);
  assign sb.state_dbg = state_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for the dual-issue scoreboard. Observed vector is
// {stallF, stallD, bubbleE1, bubbleE2, splitD}.
module tb_dual_issue_scoreboard;
  import dual_issue_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [4:0] exp_q[$];

  dual_issue_scoreboard_if dif ();

  dual_issue_scoreboard dut (
    .clk  (clk),
    .reset(reset),
    .sb   (dif.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic clear_d();
    dif.validD1 = 0; dif.rsD1 = 0; dif.rtD1 = 0; dif.writeregD1 = 0;
    dif.regwriteD1 = 0; dif.memtoregD1 = 0; dif.branchD1 = 0;
    dif.validD2 = 0; dif.rsD2 = 0; dif.rtD2 = 0; dif.writeregD2 = 0;
    dif.regwriteD2 = 0; dif.memtoregD2 = 0; dif.branchD2 = 0;
    dif.flushD = 0;
  endtask

  task automatic set_s1(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] wr, input logic rw, input logic ld, input logic br);
    dif.validD1 = v; dif.rsD1 = rs; dif.rtD1 = rt; dif.writeregD1 = wr;
    dif.regwriteD1 = rw; dif.memtoregD1 = ld; dif.branchD1 = br;
  endtask

  task automatic set_s2(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] wr, input logic rw, input logic ld, input logic br);
    dif.validD2 = v; dif.rsD2 = rs; dif.rtD2 = rt; dif.writeregD2 = wr;
    dif.regwriteD2 = rw; dif.memtoregD2 = ld; dif.branchD2 = br;
  endtask

  // Scoreboard: pop the oldest expectation and compare against the outputs.
  task automatic check(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {dif.stallF, dif.stallD, dif.bubbleE1, dif.bubbleE2, dif.splitD};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One decode cycle: inputs were driven at the negedge; settle, check, advance.
  task automatic step(input logic [4:0] exp, input string tag);
    exp_q.push_back(exp);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    clear_d();
    for (int i = 0; i < n; i++) step(5'b00000, "idle");
  endtask

  initial begin
    logic [RW-1:0] r;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_d();
    exp_q.push_back(5'b00000);
    #1;
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Load-use on a randomly chosen register.
    r = RW'($urandom_range(2, 31));
    set_s1(1, 5'd29, 5'd0, r, 1, 1, 0);
    step(5'b00000, "lu_load");
    set_s1(1, r, 5'd1, 5'd9, 1, 0, 0);
    step(5'b11110, "lu_stall");
    step(5'b00000, "lu_issue");
    idle(2);

    // Intra-bundle RAW: add $5,$1,$2 / sub $6,$5,$3.
    set_s1(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    set_s2(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    step(5'b11010, "raw_split");
    step(5'b00101, "raw_second");
    set_s1(1, 5'd1, 5'd2, 5'd10, 1, 0, 0);
    set_s2(1, 5'd3, 5'd4, 5'd11, 1, 0, 0);
    step(5'b00000, "raw_back_pair");

    // WAW within a bundle.
    set_s1(1, 5'd1, 5'd2, 5'd12, 1, 0, 0);
    set_s2(1, 5'd3, 5'd4, 5'd12, 1, 0, 0);
    step(5'b11010, "waw_split");
    step(5'b00101, "waw_second");
    idle(2);

    // Branch on a load issued in lane 2.
    set_s2(1, 5'd29, 5'd0, 5'd4, 1, 1, 0);
    step(5'b00000, "brld_load");
    clear_d();
    set_s1(1, 5'd4, 5'd0, 5'd0, 0, 0, 1);
    step(5'b11110, "brld_stall1");
    step(5'b11110, "brld_stall2");
    step(5'b00000, "brld_issue");
    idle(2);

    // Register 0 never matches.
    set_s1(1, 5'd29, 5'd0, 5'd0, 1, 1, 0);
    step(5'b00000, "zero_load");
    set_s1(1, 5'd0, 5'd0, 5'd1, 1, 0, 0);
    step(5'b00000, "zero_use");
    set_s1(1, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step(5'b00000, "zero_branch");
    idle(2);

    // Flush while in SECOND.
    set_s1(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    set_s2(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    step(5'b11010, "flush_split");
    dif.flushD = 1'b1;
    step(5'b00111, "flush_in_second");
    clear_d();
    step(5'b00000, "flush_pair_next");
    idle(2);

    // Split whose second slot still load-uses slot 1.
    set_s1(1, 5'd29, 5'd0, 5'd8, 1, 1, 0);
    set_s2(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
    step(5'b11010, "sec_split");
    step(5'b11111, "sec_hazard");
    step(5'b00101, "sec_issue");
    idle(2);

    // Async reset between edges while in SECOND.
    set_s1(1, 5'd29, 5'd0, 5'd8, 1, 1, 0);
    set_s2(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
    step(5'b11010, "rst_split");
    exp_q.push_back(5'b11111);
    #1;
    check("rst_pre_second");
    #2;
    reset = 1'b1;
    clear_d();
    exp_q.push_back(5'b00000);
    #1;
    check("rst_async_outputs");
    reset = 1'b0;
    exp_q.push_back(5'b00000);
    #1;
    check("rst_released");
    @(negedge clk);
    set_s1(1, 5'd8, 5'd0, 5'd0, 0, 0, 1);
    step(5'b00000, "rst_shadow_cleared");
    set_s1(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
    step(5'b00000, "rst_use_after");
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
